// File: rtl/slave_responder.sv
// Memory-mapped crossbar target: register-file memory behind a req/ack handshake
// with a fixed wait-state latency (stretchable by hold) and saturating txn counters.
module slave_responder #(
    parameter int N        = 32,
    parameter int DEPTH    = 16,
    parameter int WAIT     = 2,
    parameter int ADDR_LSB = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [N-1:0] addr,
    input  logic         cmd,
    input  logic [N-1:0] wdata,
    input  logic         hold,
    output logic         ack,
    output logic [N-1:0] rdata,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);
    localparam int         IW       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cmd_q, cmd_d;
    logic [N-1:0]    wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic [N-1:0]    rdata_q, rdata_d;
    logic [15:0]     rd_count_q, rd_count_d;
    logic [15:0]     wr_count_q, wr_count_d;
    logic            mem_we;
    logic [N-1:0]    mem_q [DEPTH];

    // Only the index field of addr is decoded; upper bits alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (!hold && cnt_q == 4'd0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = addr[ADDR_LSB +: IW];
                    cmd_d   = cmd;
                    wdata_d = wdata;
                    cnt_d   = WAIT_CNT;
                end
            end
            BUSY: begin
                if (!hold) begin
                    if (cnt_q == 4'd0) begin
                        ack_d = 1'b1;
                        if (cmd_q) mem_we  = 1'b1;
                        else       rdata_d = mem_q[idx_q];
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ACK: begin
                if (cmd_q) begin
                    if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                end else begin
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            cmd_q      <= 1'b0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Per-word flops so the whole array clears on reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                mem_q[gi] <= '0;
            else if (mem_we && idx_q == IW'(gi))
                mem_q[gi] <= wdata_q;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: doc/slave_responder.md
Name: slave_responder

Overview:
Memory-mapped target that sits on one slave port of the 2x2 crossbar and terminates the req/addr/cmd/wdata -> ack/rdata protocol.
- Holds a small register-file memory.
- Serves one transaction at a time with a fixed, parameterised wait-state latency, stretchable by a hold input.
- Issues a single-cycle ack, with rdata valid on reads.
- Keeps read and write transaction counters for bring-up and verification.

Parameters:
- N, 32: data and address width.
- DEPTH, 16: number of N-bit memory words; power of two, >= 2.
- WAIT, 2: wait-state cycles between capture and ack; 0..15.
- ADDR_LSB, 2: lowest address bit used for the word index (byte-addressed words).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  1  request from crossbar; held with addr/cmd/wdata until ack.
- addr  in  N  byte address; index = addr[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB], upper bits ignored.
- cmd  in  1  0 = read, 1 = write.
- wdata  in  N  write data.
- hold  in  1  stretch the wait phase while high.
- ack  out  1  one-cycle completion pulse.
- rdata  out  N  read data, valid in the ack cycle of a read.
- rd_count  out  16  completed reads, saturating.
- wr_count  out  16  completed writes, saturating.

Behaviour:
- Reset (rst=0, asynchronous; released synchronously by the system):
  - state=IDLE, ack=0, rdata=0, rd_count=0, wr_count=0, wait counter=0.
  - All DEPTH memory words cleared to 0.
  - Reset mid-transaction aborts it: no ack, no memory write.
- All outputs are registered.
- States: IDLE, BUSY, ACK.
- IDLE:
  - If req=1 at a rising edge: capture addr index, cmd and wdata; load cnt=WAIT; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If hold=1: stay, cnt unchanged.
  - Else if cnt==0: go to ACK.
  - Else cnt=cnt-1.
  - On the edge entering ACK:
    - Read: rdata <= mem[index].
    - Write: mem[index] <= captured wdata; rdata unchanged.
- ACK:
  - ack=1 for exactly this one cycle.
  - Counter matching the captured cmd increments at the edge leaving ACK, saturating at 16'hFFFF.
  - Next state is always IDLE.
- ack is 0 in every state except ACK.
- Latency, no hold: req sampled in IDLE at cycle C -> ack high in cycle C+WAIT+2.
  - WAIT=0 -> ack in C+2.
  - Each cycle with hold=1 while in BUSY adds one cycle.
- Throughput:
  - IDLE re-samples req in the cycle after ACK.
  - A master still holding req then starts a new transaction; the crossbar drops or re-grants req in the ack cycle.
  - Minimum transaction period is WAIT+3 cycles.
- Captured values govern the transaction:
  - req, addr, cmd and wdata changes after capture are ignored.
  - req dropping during BUSY still completes and acks (protocol violation tolerated, not flagged).
- hold in IDLE or ACK: no effect.
- rdata keeps its last read value across writes and idle cycles.
- Address aliasing: index wraps modulo DEPTH, so addr 0x40 and 0x00 hit the same word when DEPTH=16 and ADDR_LSB=2.
- Read of a word written by the immediately preceding transaction returns the new value.

Test Plan:
- Reset then read addr 0x0C, WAIT=2 -> ack high exactly in C+4, rdata=0, rd_count=1, wr_count=0.
- Write addr 0x08 wdata 0xDEADBEEF, then read addr 0x08 back-to-back:
  - Each ack is one cycle.
  - The second transaction is captured in the cycle after the first ack.
  - rdata=0xDEADBEEF; wr_count=1, rd_count=1.
- hold=1 for 3 cycles during BUSY of a read, WAIT=2 -> ack in C+7; ack is never high while hold=1.
- Alias check, DEPTH=16: write 0x11111111 to addr 0x44, then read addr 0x04 -> rdata=0x11111111.
- Reset mid-write:
  - Write 0xCAFEF00D to addr 0x10; assert rst=0 during BUSY.
  - Expect ack=0 immediately and no ack afterwards.
  - Subsequent read of 0x10 returns 0; counters are 0 before that read.
- Saturation:
  - Force wr_count to 16'hFFFE via 2 writes after preload, or run 65537 writes.
  - Expect wr_count to stick at 16'hFFFF.
- Connect two instances to crossbar slave ports 1 and 2 with both masters issuing concurrently:
  - Every master req gets exactly one ack.
  - Read data matches the per-slave shadow model.
